shift_register_multi_mode: RTL
==============================

// Module: shift_register_multi_mode
// PURPOSE
//  Parametrised multi-mode shift register; successor to the fixed 3-bit serial shifter.
//  - Holds DEPTH stages of WIDTH bits each.
//  - Modes: shift left, shift right, rotate left, rotate right; plus parallel load and clear.
//  - Tracks the valid fill level and emits a one-cycle pulse with each word shifted out.
//  - Feeds the same cascaded-NOR reduction logic that consumes shift-register outputs today.
// PARAMETERS
//  WIDTH  1  bits per stage
//  DEPTH  3  number of stages (>=1)
//  CNT_W  $clog2(DEPTH+1)  fill counter width (derived, do not override)
// PORTS
//  clk             in   1            clock, all state updates on posedge
//  rst             in   1            synchronous active-high reset
//  mode            in   2            00 shl, 01 shr, 10 rotl, 11 rotr
//  in_valid        in   1            perform one mode step this cycle
//  in_data         in   WIDTH        serial word entering on shl/shr
//  load            in   1            parallel load request
//  load_data       in   WIDTH*DEPTH  parallel image, stage i = [i*WIDTH +: WIDTH]
//  clear           in   1            zero stages and count
//  chain_in        in   1            seed for NOR chain
//  out_stages      out  WIDTH*DEPTH  registered stage contents, stage 0 in LSBs
//  shift_out_valid out  1            registered pulse: a valid word was ejected
//  shift_out_data  out  WIDTH        ejected word, meaningful while shift_out_valid=1
//  fill_count      out  CNT_W        number of valid stages, 0..DEPTH
//  full            out  1            fill_count==DEPTH
//  empty           out  1            fill_count==0
//  nor_chain       out  1            cascaded NOR result (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - out_stages=0, fill_count=0, shift_out_valid=0, shift_out_data=0.
//   - empty=1, full=0.
//  Priority per cycle: rst > clear > load > in_valid step > hold.
//  clear: stages=0, fill_count=0, shift_out_valid=0.
//  load:
//   - stages=load_data, fill_count=DEPTH, shift_out_valid=0.
//   - in_valid is ignored that cycle.
//  shl (mode 00):
//   - stage[i]<=stage[i-1], stage[0]<=in_data.
//   - The ejected word is stage[DEPTH-1].
//  shr (mode 01):
//   - stage[i]<=stage[i+1], stage[DEPTH-1]<=in_data.
//   - The ejected word is stage[0].
//  shl/shr fill and eject rules:
//   - If fill_count<DEPTH: fill_count+1 and no eject pulse.
//   - Else: fill_count holds at DEPTH; next cycle shift_out_valid=1 with the ejected word.
//  rotl/rotr (modes 10/11):
//   - Circular move one stage; in_data is ignored.
//   - fill_count unchanged, shift_out_valid=0.
//  General timing:
//   - shift_out_valid is exactly one cycle per qualifying step, else 0.
//   - shift_out_data holds its last value when shift_out_valid=0.
//   - All outputs are registered; latency is 1 cycle from the input edge to out_stages.
//   - full and empty decode fill_count combinationally.
//   - mode may change every cycle; no state is kept per mode.
//  DEPTH=1: shl and shr are identical; rotate holds contents.
//  Reset or clear asserted mid-stream discards any pending eject, with no pulse the following cycle.
// CONFIGURATION
//  Macro SHREG_NOR_CHAIN_EN.
//  Defined:
//   - n0 = ~(chain_in | stage[0][0]); n_i = ~(n_{i-1} | stage[i][0]) for i=1..DEPTH-1.
//   - nor_chain = n_{DEPTH-1}, combinational from registered stages and chain_in.
//  Undefined:
//   - No NOR logic is built; nor_chain is tied to 0 and chain_in is unused.
// TESTING (WIDTH=1, DEPTH=3 unless stated)
//  1. rst=1 for 2 cycles with stages preloaded -> out_stages=000, fill_count=0, empty=1.
//  2. shl, in_valid with data 1,0,1 -> out_stages=101, full=1, no pulse.
//     Then shl with data 0 -> out_stages=010; next cycle shift_out_valid=1, shift_out_data=1.
//  3. WIDTH=4, DEPTH=4: load 0xDCBA, then rotr x1 -> 0xADCB.
//     Then rotl x2 -> 0xCBAD, fill_count=4, shift_out_valid stays 0.
//  4. Same cycle: load=1, clear=1, in_valid=1 -> stages=0, fill_count=0.
//     Next cycle: load=1 alone -> stages=load_data, fill_count=DEPTH.
//  5. Full, shr, in_valid, rst=1 same cycle -> stages=0 and no pulse next cycle.
//     Repeat with clear instead of rst -> same result.
//  6. SHREG_NOR_CHAIN_EN defined, chain_in=0:
//     stages=000 -> nor_chain=1; stages=101 -> nor_chain=0.
//     Macro undefined -> nor_chain=0 always.

Source files
------------

// File: rtl/shift_register_multi_mode_if.sv
// Bundles the control, data and status signals of shift_register_multi_mode.
// The master drives the controls; the slave is the shift register itself.
interface shift_register_multi_mode_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic [1:0]             mode;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   load;
  logic [WIDTH*DEPTH-1:0] load_data;
  logic                   clear;
  logic                   chain_in;
  logic [WIDTH*DEPTH-1:0] out_stages;
  logic                   shift_out_valid;
  logic [WIDTH-1:0]       shift_out_data;
  logic [CNT_W-1:0]       fill_count;
  logic                   full;
  logic                   empty;
  logic                   nor_chain;

  modport master (
    output mode, in_valid, in_data, load, load_data, clear, chain_in,
    input  out_stages, shift_out_valid, shift_out_data, fill_count, full, empty, nor_chain
  );

  modport slave (
    input  mode, in_valid, in_data, load, load_data, clear, chain_in,
    output out_stages, shift_out_valid, shift_out_data, fill_count, full, empty, nor_chain
  );
endinterface

// File: rtl/shift_register_multi_mode.sv
// Parametrised DEPTH x WIDTH shift register with shl/shr/rotl/rotr, load, clear, fill
// tracking and eject pulse. Define SHREG_NOR_CHAIN_EN to build the cascaded-NOR output.
module shift_register_multi_mode #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                        clk,
  input logic                        rst,
  shift_register_multi_mode_if.slave bus
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [WIDTH-1:0]       stage_r     [DEPTH];
  logic [WIDTH-1:0]       stage_nxt_s [DEPTH];
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   vld_r;
  logic                   vld_nxt_s;
  logic [WIDTH-1:0]       data_r;
  logic [WIDTH-1:0]       data_nxt_s;
  logic [WIDTH*DEPTH-1:0] stages_flat_s;
  logic [WIDTH-1:0]       eject_s;

  // Next-state decode: clear > load > step > hold.
  always_comb begin
    stage_nxt_s = stage_r;
    cnt_nxt_s   = cnt_r;
    vld_nxt_s   = 1'b0;
    data_nxt_s  = data_r;
    eject_s     = bus.mode[0] ? stage_r[0] : stage_r[DEPTH-1];
    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) stage_nxt_s[i] = '0;
      cnt_nxt_s = '0;
    end else if (bus.load) begin
      for (int i = 0; i < DEPTH; i++) stage_nxt_s[i] = bus.load_data[i*WIDTH +: WIDTH];
      cnt_nxt_s = DEPTH_C;
    end else if (bus.in_valid) begin
      case (bus.mode)
        2'b00: begin
          for (int i = 1; i < DEPTH; i++) stage_nxt_s[i] = stage_r[i-1];
          stage_nxt_s[0] = bus.in_data;
        end
        2'b01: begin
          for (int i = 0; i < DEPTH - 1; i++) stage_nxt_s[i] = stage_r[i+1];
          stage_nxt_s[DEPTH-1] = bus.in_data;
        end
        2'b10: begin
          for (int i = 1; i < DEPTH; i++) stage_nxt_s[i] = stage_r[i-1];
          stage_nxt_s[0] = stage_r[DEPTH-1];
        end
        2'b11: begin
          for (int i = 0; i < DEPTH - 1; i++) stage_nxt_s[i] = stage_r[i+1];
          stage_nxt_s[DEPTH-1] = stage_r[0];
        end
        default: stage_nxt_s = stage_r;
      endcase
      // Only the serial shifts move fill level or eject; rotates keep every word.
      if (!bus.mode[1]) begin
        if (cnt_r < DEPTH_C) begin
          cnt_nxt_s = cnt_r + ONE_C;
        end else begin
          vld_nxt_s  = 1'b1;
          data_nxt_s = eject_s;
        end
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      stage_nxt_s = stage_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
      cnt_r  <= '0;
      vld_r  <= 1'b0;
      data_r <= '0;
    end else begin
      stage_r <= stage_nxt_s;
      cnt_r   <= cnt_nxt_s;
      vld_r   <= vld_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  // Flatten stages, stage 0 in the LSBs.
  always_comb begin
    stages_flat_s = '0;
    for (int i = 0; i < DEPTH; i++) stages_flat_s[i*WIDTH +: WIDTH] = stage_r[i];
  end

  assign bus.out_stages      = stages_flat_s;
  assign bus.shift_out_valid = vld_r;
  assign bus.shift_out_data  = data_r;
  assign bus.fill_count      = cnt_r;
  assign bus.full            = (cnt_r == DEPTH_C);
  assign bus.empty           = (cnt_r == '0);

`ifdef SHREG_NOR_CHAIN_EN
  logic nor_s;

  // Cascaded NOR seeded by chain_in, one tap per stage LSB.
  always_comb begin
    nor_s = bus.chain_in;
    for (int i = 0; i < DEPTH; i++) nor_s = ~(nor_s | stage_r[i][0]);
  end

  assign bus.nor_chain = nor_s;
`else
  assign bus.nor_chain = 1'b0;
`endif
endmodule
